// File: rtl/seq_detector_if.sv
// Serial pattern-detector port bundle: sample stream, control strobes and match outputs.
interface seq_detector_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic             en;
  logic             a;
  logic             overlap;
  logic             load;
  logic [N-1:0]     pat_i;
  logic             clr_cnt;
  logic             y;
  logic [CNT_W-1:0] count;

  modport master (output en, a, overlap, load, pat_i, clr_cnt, input y, count);
  modport slave  (input en, a, overlap, load, pat_i, clr_cnt, output y, count);
endinterface

// File: rtl/seq_detector.sv
// Serial pattern detector: runtime-loadable N-bit pattern, overlap/non-overlap
// matching and a saturating match counter. One registered y pulse per match.
module seq_detector #(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter int           CNT_W   = 8
) (
  input  logic           clk,
  input  logic           reset,
  seq_detector_if.slave  sif
);
  localparam int               FW        = $clog2(N + 1);
  localparam logic [FW-1:0]    FILL_FULL = FW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [N-1:0]     pat_q, pat_d;
  logic [N-1:0]     hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0]     hist_n;
  logic [FW-1:0]    fill_n;
  logic             match;

  // fill counts valid history bits so stale or cleared bits can never match
  always_comb begin
    hist_n = {hist_q[N-2:0], sif.a};
    fill_n = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FW'(1);
    match  = sif.en && !sif.load && (fill_n == FILL_FULL) && (hist_n == pat_q);
  end

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    y_d    = 1'b0;
    if (sif.load) begin
      pat_d  = sif.pat_i;
      hist_d = '0;
      fill_d = '0;
    end else if (sif.en) begin
      hist_d = hist_n;
      y_d    = match;
      fill_d = (!sif.overlap && match) ? '0 : fill_n;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (sif.clr_cnt)
      cnt_d = match ? CNT_W'(1) : '0;
    else if (match && cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sif.y     = y_q;
  assign sif.count = cnt_q;
endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: vector table on a 1011/8-bit instance,
// hand-written sequences for saturation (1111/2-bit instance) and async reset.
module tb_seq_detector;
  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  seq_detector_if #(.N(4), .CNT_W(8)) m1 ();
  seq_detector_if #(.N(4), .CNT_W(2)) m2 ();

  seq_detector #(.N(4), .PATTERN(4'b1011), .CNT_W(8)) dut1 (.clk(clk), .reset(reset), .sif(m1));
  seq_detector #(.N(4), .PATTERN(4'b1111), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .sif(m2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pre_rst;
    logic       en;
    logic       a;
    logic       ov;
    logic       load;
    logic [3:0] pat;
    logic       clr;
    logic       ey;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic pr, input logic en, input logic a, input logic ov,
                     input logic ld, input logic [3:0] pat, input logic clr,
                     input logic ey, input logic [7:0] ec);
    vec_t v;
    v.pre_rst = pr; v.en = en; v.a = a; v.ov = ov; v.load = ld;
    v.pat = pat; v.clr = clr; v.ey = ey; v.ecnt = ec;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    m1.en = 0; m1.a = 0; m1.overlap = 1; m1.load = 0; m1.pat_i = '0; m1.clr_cnt = 0;
    m2.en = 0; m2.a = 0; m2.overlap = 1; m2.load = 0; m2.pat_i = '0; m2.clr_cnt = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    reset = 0;
    #2 reset = 1;
  endtask

  task automatic step2(input logic en, input logic a, input logic clr,
                       input logic ey, input logic [1:0] ec, input string nm);
    @(negedge clk);
    m2.en = en; m2.a = a; m2.clr_cnt = clr;
    @(posedge clk);
    #1;
    chk({nm, "_y"}, 32'(m2.y), 32'(ey));
    chk({nm, "_cnt"}, 32'(m2.count), 32'(ec));
  endtask

  task automatic step1(input logic a, input logic ey, input logic [7:0] ec, input string nm);
    @(negedge clk);
    m1.en = 1; m1.a = a; m1.load = 0; m1.clr_cnt = 0;
    @(posedge clk);
    #1;
    chk({nm, "_y"}, 32'(m1.y), 32'(ey));
    chk({nm, "_cnt"}, 32'(m1.count), 32'(ec));
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    #1;
    chk("rst_y", 32'(m1.y), 32'd0);
    chk("rst_cnt", 32'(m1.count), 32'd0);
    chk("rst_cnt2", 32'(m2.count), 32'd0);

    // overlap=1: 1011011 matches after bits 4 and 7
    add(1,1,1,1,0,4'h0,0, 0,0); add(0,1,0,1,0,4'h0,0, 0,0); add(0,1,1,1,0,4'h0,0, 0,0);
    add(0,1,1,1,0,4'h0,0, 1,1); add(0,1,0,1,0,4'h0,0, 0,1); add(0,1,1,1,0,4'h0,0, 0,1);
    add(0,1,1,1,0,4'h0,0, 1,2);
    // overlap=0: same stream, only bit 4 (history 1011 at bit 7 but fill=3)
    add(1,1,1,0,0,4'h0,0, 0,0); add(0,1,0,0,0,4'h0,0, 0,0); add(0,1,1,0,0,4'h0,0, 0,0);
    add(0,1,1,0,0,4'h0,0, 1,1); add(0,1,0,0,0,4'h0,0, 0,1); add(0,1,1,0,0,4'h0,0, 0,1);
    add(0,1,1,0,0,4'h0,0, 0,1);
    // 0,1,1 then load 0110 (en/a ignored); stale bits would match on first new 0
    add(1,1,0,1,0,4'h0,0, 0,0); add(0,1,1,1,0,4'h0,0, 0,0); add(0,1,1,1,0,4'h0,0, 0,0);
    add(0,1,1,1,1,4'h6,0, 0,0);
    add(0,1,0,1,0,4'h0,0, 0,0); add(0,1,1,1,0,4'h0,0, 0,0); add(0,1,1,1,0,4'h0,0, 0,0);
    add(0,1,0,1,0,4'h0,0, 1,1); add(0,1,1,1,0,4'h0,0, 0,1); add(0,1,1,1,0,4'h0,0, 0,1);
    add(0,1,0,1,0,4'h0,0, 1,2);
    // 1,0, three-cycle en gap with a=1, then 1,1
    add(1,1,1,1,0,4'h0,0, 0,0); add(0,1,0,1,0,4'h0,0, 0,0);
    add(0,0,1,1,0,4'h0,0, 0,0); add(0,0,1,1,0,4'h0,0, 0,0); add(0,0,1,1,0,4'h0,0, 0,0);
    add(0,1,1,1,0,4'h0,0, 0,0); add(0,1,1,1,0,4'h0,0, 1,1);
    add(0,0,0,1,0,4'h0,0, 0,1);
    // overlap switched off right at a match edge: next 1011 needs 4 fresh bits
    add(1,1,1,1,0,4'h0,0, 0,0); add(0,1,0,1,0,4'h0,0, 0,0); add(0,1,1,1,0,4'h0,0, 0,0);
    add(0,1,1,0,0,4'h0,0, 1,1); add(0,1,0,0,0,4'h0,0, 0,1); add(0,1,1,0,0,4'h0,0, 0,1);
    add(0,1,1,0,0,4'h0,0, 0,1); add(0,1,1,1,0,4'h0,0, 0,1);
    // clr_cnt with and without a coincident match
    add(0,1,0,1,0,4'h0,0, 0,1); add(0,1,1,1,0,4'h0,0, 0,1); add(0,1,1,1,0,4'h0,1, 1,1);
    add(0,0,0,1,0,4'h0,1, 0,0);

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].pre_rst) apply_reset();
      @(negedge clk);
      m1.en = vq[i].en; m1.a = vq[i].a; m1.overlap = vq[i].ov; m1.load = vq[i].load;
      m1.pat_i = vq[i].pat; m1.clr_cnt = vq[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_y", i), 32'(m1.y), 32'(vq[i].ey));
      chk($sformatf("vec%0d_cnt", i), 32'(m1.count), 32'(vq[i].ecnt));
    end

    // saturation: 2-bit counter, all-ones pattern, back-to-back matches
    apply_reset();
    step2(1,1,0, 0,0, "sat1"); step2(1,1,0, 0,0, "sat2"); step2(1,1,0, 0,0, "sat3");
    step2(1,1,0, 1,1, "sat4"); step2(1,1,0, 1,2, "sat5"); step2(1,1,0, 1,3, "sat6");
    step2(1,1,0, 1,3, "sat7"); step2(1,1,0, 1,3, "sat8");
    step2(1,1,1, 1,1, "clr_match"); step2(0,1,1, 0,0, "clr_idle");

    // async reset while y is high drops outputs without a clock edge
    apply_reset();
    m1.overlap = 1;
    step1(1, 0,0, "ra1"); step1(0, 0,0, "ra2"); step1(1, 0,0, "ra3"); step1(1, 1,1, "ra4");
    #2 reset = 0;
    #1;
    chk("async_y", 32'(m1.y), 32'd0);
    chk("async_cnt", 32'(m1.count), 32'd0);
    @(negedge clk) reset = 1;

    // reset after 1,0,1 must discard history: the following 1 is not a match
    apply_reset();
    step1(1, 0,0, "rb1"); step1(0, 0,0, "rb2"); step1(1, 0,0, "rb3");
    #2 reset = 0;
    #1 chk("async_cnt_b", 32'(m1.count), 32'd0);
    @(negedge clk) reset = 1;
    step1(1, 0,0, "post_rst");
    step1(0, 0,0, "post_rst2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
